// File: rtl/bno055_txn_arbiter.sv
// bno055_txn_arbiter
// Shares one single-byte I2C read/write engine between NUM_REQ requesters.
// Round-robin arbitration, one transaction in flight, a one-cycle opcode
// strobe per transaction, a done-timeout watchdog and a fixed idle gap on
// the bus between transactions. All outputs come straight from registers.
module bno055_txn_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 2500000,
  parameter int GAP_CYC     = 250
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ-1:0]     i_req_wr,
  input  logic [8*NUM_REQ-1:0]   i_req_addr,
  input  logic [8*NUM_REQ-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [NUM_REQ-1:0]     o_ack,
  output logic [NUM_REQ-1:0]     o_err,
  output logic [7:0]             o_rd_data,
  output logic                   o_busy,
  output logic [1:0]             o_opcode,
  output logic [7:0]             o_reg_addr,
  output logic [7:0]             o_tx_data,
  input  logic                   i_done,
  input  logic [7:0]             i_rd_data
);

  // Index width for requester numbers and the round-robin pointer.
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Watchdog timer counts 0..TIMEOUT_CYC-1 while waiting on the engine.
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  // Gap counter counts 0..GAP_CYC-1; keep at least one bit when the gap is zero.
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST   = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : {GW{1'b0}};

  // Engine opcodes.
  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Controller state.
  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            wr_q, wr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;

  // Registered outputs.
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic [1:0]         opcode_q, opcode_d;
  logic [7:0]         reg_addr_q, reg_addr_d;
  logic [7:0]         tx_data_q, tx_data_d;

  // Arbitration result for the current cycle.
  logic               pick_found_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_wr_s;
  logic [7:0]         pick_addr_s;
  logic [7:0]         pick_wdata_s;
  logic [IW-1:0]      idx_next_s;
  int                 cand_s;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      vec[k] = (int'(idx) == k);
    end
    return vec;
  endfunction

  // Round-robin search: walk from the highest offset down so the candidate
  // closest to rr_q (offset 0) is the one that survives.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IW{1'b0}};
    cand_s       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s       = (int'(rr_q) + k) % NUM_REQ;
      pick_idx_s   = i_req[cand_s] ? IW'(cand_s) : pick_idx_s;
      pick_found_s = pick_found_s | i_req[cand_s];
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    pick_wr_s    = 1'b0;
    pick_addr_s  = 8'h00;
    pick_wdata_s = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_wr_s    = (int'(pick_idx_s) == k) ? i_req_wr[k]          : pick_wr_s;
      pick_addr_s  = (int'(pick_idx_s) == k) ? i_req_addr[8*k +: 8]  : pick_addr_s;
      pick_wdata_s = (int'(pick_idx_s) == k) ? i_req_wdata[8*k +: 8] : pick_wdata_s;
    end
  end

  // Requester after the one being served, wrapping at NUM_REQ.
  assign idx_next_s = (idx_q == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : idx_q + IW'(1);

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    wr_d       = wr_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    ack_d      = {NUM_REQ{1'b0}};
    err_d      = {NUM_REQ{1'b0}};
    rd_data_d  = rd_data_q;
    opcode_d   = OP_STOP;
    reg_addr_d = reg_addr_q;
    tx_data_d  = tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          idx_d      = pick_idx_s;
          wr_d       = pick_wr_s;
          reg_addr_d = pick_addr_s;
          tx_data_d  = pick_wdata_s;
          opcode_d   = pick_wr_s ? OP_WRITE : OP_READ;
          state_d    = ST_ISSUE;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        timer_d = {TW{1'b0}};
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A completion on the very last watchdog cycle still counts as success.
        if (i_done) begin
          ack_d     = onehot(idx_q);
          rd_data_d = wr_q ? rd_data_q : i_rd_data;
          state_d   = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          err_d     = onehot(idx_q);
          state_d   = ST_RESP;
        end else begin
          timer_d   = timer_q + TW'(1);
        end
      end

      ST_RESP: begin
        rr_d = idx_next_s;
        if (GAP_CYC == 0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d   = {GW{1'b0}};
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d   = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Grant covers ISSUE, WAIT and the response cycle of the same transaction.
    gnt_d  = ((state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_RESP))
             ? onehot(idx_d) : {NUM_REQ{1'b0}};
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IW{1'b0}};
      rr_q       <= {IW{1'b0}};
      wr_q       <= 1'b0;
      timer_q    <= {TW{1'b0}};
      gap_q      <= {GW{1'b0}};
      gnt_q      <= {NUM_REQ{1'b0}};
      ack_q      <= {NUM_REQ{1'b0}};
      err_q      <= {NUM_REQ{1'b0}};
      rd_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      opcode_q   <= OP_STOP;
      reg_addr_q <= 8'h00;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      wr_q       <= wr_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      opcode_q   <= opcode_d;
      reg_addr_q <= reg_addr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_ack      = ack_q;
  assign o_err      = err_q;
  assign o_rd_data  = rd_data_q;
  assign o_busy     = busy_q;
  assign o_opcode   = opcode_q;
  assign o_reg_addr = reg_addr_q;
  assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_bno055_txn_arbiter.sv
// Testbench for bno055_txn_arbiter: requester tasks raise requests and record
// the operands they expect to see; a bus model acts as the engine, predicts
// grant order from the round-robin rule and pushes expected responses; a
// separate monitor pops and compares every ack/err pulse.
module tb_bno055_txn_arbiter;
  localparam int N   = 3;
  localparam int TO  = 100;
  localparam int GAP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [N-1:0]       req, req_wr;
  logic [8*N-1:0]     req_addr, req_wdata;
  logic [N-1:0]       o_gnt, o_ack, o_err;
  logic [7:0]         o_rd_data, o_reg_addr, o_tx_data;
  logic               o_busy;
  logic [1:0]         o_opcode;
  logic               done;
  logic [7:0]         eng_rd_data;

  logic               req_a  [N];
  logic               wr_a   [N];
  logic [7:0]         addr_a [N];
  logic [7:0]         wd_a   [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req[k]             = req_a[k];
      req_wr[k]          = wr_a[k];
      req_addr[8*k +: 8] = addr_a[k];
      req_wdata[8*k +: 8] = wd_a[k];
    end
  end

  bno055_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_gnt(o_gnt),
    .o_ack(o_ack), .o_err(o_err), .o_rd_data(o_rd_data), .o_busy(o_busy),
    .o_opcode(o_opcode), .o_reg_addr(o_reg_addr), .o_tx_data(o_tx_data),
    .i_done(done), .i_rd_data(eng_rd_data)
  );

  typedef struct { bit wr; logic [7:0] addr; logic [7:0] wd; } txn_t;
  typedef struct { int idx; bit is_err; logic [7:0] rd; int at; } resp_t;

  txn_t  pend   [N];
  bit    pend_v [N];
  resp_t exp_resp [$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int eng_lat = -1;   // -1 random, 0 never answer, >0 fixed latency
  int eng_rd  = -1;   // -1 random read byte, else fixed
  bit stray_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_first(int ptr, logic [N-1:0] r);
    for (int j = 0; j < N; j++) begin
      if (r[(ptr + j) % N]) return (ptr + j) % N;
    end
    return -1;
  endfunction

  // Bus model: engine behaviour, issue prediction and per-cycle checks.
  initial begin
    int idle_at, rr, cur_idx, issue_at, resp_at, done_at, exp_issue_at, exp_idx, m, lat;
    bit txn_active, sched, to, stray;
    logic [7:0] last_rd, rd_new, cur_addr, cur_wd;
    txn_t t;
    resp_t r;
    idle_at = 0; rr = 0; cur_idx = 0; issue_at = 0; resp_at = 0; done_at = -1;
    exp_issue_at = 0; exp_idx = 0; txn_active = 0; sched = 0;
    last_rd = 8'h00; rd_new = 8'h00; cur_addr = 8'h00; cur_wd = 8'h00;
    done = 1'b0; eng_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      m = cyc;
      if (!rst_n) begin
        idle_at = m + 1; rr = 0; txn_active = 0; sched = 0; done_at = -1;
        last_rd = 8'h00; exp_resp.delete(); done = 1'b0;
      end else begin
        if (o_opcode != 2'd0) begin
          chk("issue_expected", 32'(sched), 32'd1);
          if (sched) chk("issue_cycle", 32'(m), 32'(exp_issue_at));
          cur_idx = sched ? exp_idx : rr_first(rr, req);
          if (cur_idx < 0) cur_idx = 0;
          chk("issue_gnt", 32'(o_gnt), 32'(oh(cur_idx)));
          chk("issue_pending", 32'(pend_v[cur_idx]), 32'd1);
          t = pend[cur_idx];
          pend_v[cur_idx] = 1'b0;
          chk("issue_opcode", 32'(o_opcode), t.wr ? 32'd2 : 32'd1);
          chk("issue_addr", 32'(o_reg_addr), 32'(t.addr));
          chk("issue_wdata", 32'(o_tx_data), 32'(t.wd));
          cur_addr = t.addr; cur_wd = t.wd;
          if (eng_lat == 0) begin
            to = 1'b1; lat = 0;
          end else if (eng_lat > 0) begin
            to = 1'b0; lat = eng_lat;
          end else begin
            to  = ($urandom_range(0, 7) == 0);
            lat = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(1, 20));
          end
          if (to) begin
            done_at = -1; resp_at = m + TO + 1;
          end else begin
            done_at = m + lat; resp_at = m + lat + 1;
          end
          if (!to && !t.wr) begin
            rd_new  = (eng_rd >= 0) ? 8'(eng_rd) : 8'($urandom);
            last_rd = rd_new;
          end
          r.idx = cur_idx; r.is_err = to; r.rd = last_rd; r.at = resp_at;
          exp_resp.push_back(r);
          rr = (cur_idx + 1) % N;
          idle_at = resp_at + GAP + 1;
          txn_active = 1'b1; sched = 1'b0; issue_at = m;
        end else if (sched && m == exp_issue_at) begin
          chk("issue_missing", 32'(o_opcode), 32'd1);
          sched = 1'b0;
        end
        chk("busy", 32'(o_busy), 32'(txn_active || m < idle_at));
        chk("gnt", 32'(o_gnt), txn_active ? 32'(oh(cur_idx)) : 32'd0);
        if (txn_active && m < resp_at) begin
          chk("addr_hold", 32'(o_reg_addr), 32'(cur_addr));
          chk("wdata_hold", 32'(o_tx_data), 32'(cur_wd));
        end
        if (txn_active && m == resp_at) txn_active = 1'b0;
        if (!txn_active && !sched && m >= idle_at && req != '0) begin
          sched = 1'b1; exp_issue_at = m + 1; exp_idx = rr_first(rr, req);
        end
        stray = stray_en && !(txn_active && m > issue_at && m < resp_at)
                && ($urandom_range(0, 5) == 0);
        done = (m == done_at) || stray;
        eng_rd_data = (m == done_at) ? rd_new : 8'($urandom);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT pulses ack/err.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_resp.size() > 0 && exp_resp[0].at < cyc) begin
          r = exp_resp.pop_front();
          chk("resp_missing", 32'(cyc), 32'(r.at));
        end
        if (o_ack != '0 || o_err != '0) begin
          if (exp_resp.size() == 0) begin
            chk("resp_unexpected", 32'({o_ack, o_err}), 32'd0);
          end else begin
            r = exp_resp.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(r.at));
            chk("resp_ack", 32'(o_ack), r.is_err ? 32'd0 : 32'(oh(r.idx)));
            chk("resp_err", 32'(o_err), r.is_err ? 32'(oh(r.idx)) : 32'd0);
            chk("resp_gnt", 32'(o_gnt), 32'(oh(r.idx)));
            chk("resp_rd_data", 32'(o_rd_data), 32'(r.rd));
          end
        end
      end
    end
  end

  // One requester transaction: raise, hold until own ack/err, drop.
  task automatic do_txn(input int k, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    int w;
    @(posedge clk); #1;
    pend[k].wr = wr; pend[k].addr = addr; pend[k].wd = wd; pend_v[k] = 1'b1;
    wr_a[k] = wr; addr_a[k] = addr; wd_a[k] = wd; req_a[k] = 1'b1;
    w = 0;
    while (!(o_ack[k] || o_err[k]) && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 3000) chk("req_wait_expired", 32'd1, 32'd0);
    req_a[k] = 1'b0;
  endtask

  task automatic run_req(input int k, input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 8)) @(posedge clk);
      do_txn(k, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(o_gnt), 32'd0);
    chk({tag, "_ack"},    32'(o_ack), 32'd0);
    chk({tag, "_err"},    32'(o_err), 32'd0);
    chk({tag, "_rd"},     32'(o_rd_data), 32'd0);
    chk({tag, "_busy"},   32'(o_busy), 32'd0);
    chk({tag, "_opcode"}, 32'(o_opcode), 32'd0);
    chk({tag, "_addr"},   32'(o_reg_addr), 32'd0);
    chk({tag, "_wdata"},  32'(o_tx_data), 32'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("FAIL watchdog: got still running expected finished");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    int w;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_a[k] = 1'b0; wr_a[k] = 1'b0; addr_a[k] = 8'h00; wd_a[k] = 8'h00; pend_v[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single read, fixed latency and data.
    eng_lat = 40; eng_rd = 8'hA5;
    do_txn(0, 1'b0, 8'h1A, 8'h00);
    chk("t1_rd_data", 32'(o_rd_data), 32'h0000_00A5);

    // Write leaves the read byte untouched.
    eng_lat = -1; eng_rd = -1;
    do_txn(1, 1'b1, 8'h3D, 8'h0B);
    chk("t3_rd_hold", 32'(o_rd_data), 32'h0000_00A5);

    // Two requesters held back to back: alternating grants.
    eng_lat = 15;
    fork
      begin do_txn(0, 1'b0, 8'h10, 8'h00); do_txn(0, 1'b0, 8'h11, 8'h00); end
      begin do_txn(1, 1'b1, 8'h20, 8'h55); do_txn(1, 1'b0, 8'h21, 8'h00); end
    join

    // Timeout on requester 0 while requester 1 waits its turn.
    eng_lat = 0;
    fork
      do_txn(0, 1'b0, 8'h30, 8'h00);
      begin repeat (6) @(posedge clk); eng_lat = 10; do_txn(1, 1'b1, 8'h31, 8'h77); end
    join

    // Completion on the last watchdog cycle wins over the timeout.
    eng_lat = TO;
    do_txn(2, 1'b0, 8'h40, 8'h00);

    // Requester drops its request right after the grant; the transaction still completes.
    eng_lat = 12;
    @(posedge clk); #1;
    pend[0].wr = 1'b0; pend[0].addr = 8'h42; pend[0].wd = 8'h00; pend_v[0] = 1'b1;
    wr_a[0] = 1'b0; addr_a[0] = 8'h42; wd_a[0] = 8'h00; req_a[0] = 1'b1;
    w = 0;
    while (o_gnt[0] == 1'b0 && w < 50) begin @(posedge clk); #1; w++; end
    chk("drop_granted", 32'(w < 50), 32'd1);
    req_a[0] = 1'b0;
    repeat (40) @(posedge clk);

    // Randomized traffic from all requesters.
    eng_lat = -1;
    fork
      run_req(0, 12);
      run_req(1, 12);
      run_req(2, 12);
    join

    // Reset while waiting on the engine.
    eng_lat = 0;
    @(posedge clk); #1;
    pend[2].wr = 1'b0; pend[2].addr = 8'h55; pend[2].wd = 8'h00; pend_v[2] = 1'b1;
    wr_a[2] = 1'b0; addr_a[2] = 8'h55; wd_a[2] = 8'h00; req_a[2] = 1'b1;
    w = 0;
    while (o_opcode == 2'd0 && w < 400) begin @(posedge clk); #1; w++; end
    chk("t5_issue_seen", 32'(w < 400), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    req_a[2] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with stray done pulses, then fresh requests from a reset pointer.
    repeat (150) @(posedge clk);
    eng_lat = -1;
    fork
      do_txn(1, 1'b0, 8'h61, 8'h00);
      do_txn(2, 1'b1, 8'h62, 8'h99);
    join

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_resp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
